// File: rtl/uart_rx_pkg.sv
// Shared types and encodings for the UART receive frame checker.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StData   = 3'd1,
      StParity = 3'd2,
      StStop   = 3'd3,
      StDone   = 3'd4
   } rx_state_e;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

endpackage

// File: rtl/rx_parity_gen.sv
// Expected parity bit for a received data word under the selected parity mode.
module rx_parity_gen
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            par_typ,
   output logic                  par_bit
);

   // Decode parity mode into the bit the transmitter should have sent.
   always_comb begin
      par_bit = 1'b0;
      unique case (par_typ)
         PAR_EVEN:  par_bit = ^data;
         PAR_ODD:   par_bit = ~^data;
         PAR_MARK:  par_bit = 1'b1;
         PAR_SPACE: par_bit = 1'b0;
         default:   par_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive framer: assembles data from mid-bit samples, checks parity and
// stop bits, and keeps saturating error counters.
module uart_rx_frame_check
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  bit_valid,
   input  logic                  sampled_bit,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_TYP,
   input  logic                  cnt_clr,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  frame_done,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

   localparam logic [3:0]           BitLast  = 4'(DATA_WIDTH - 1);
   localparam logic                 StopLast = 1'(STOP_BITS - 1);
   localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

   rx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  par_en_q, par_en_d;
   logic [1:0]            par_typ_q, par_typ_d;
   logic                  par_bit_q, par_bit_d;
   logic                  stp_bad_q, stp_bad_d;
   logic                  load_result;
   logic                  exp_par;
   logic [DATA_WIDTH-1:0] pdata_q;
   logic                  par_err_q, stp_err_q;
   logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
   logic [CNT_WIDTH-1:0]  stp_cnt_q, stp_cnt_d;

   rx_parity_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data    (shift_q),
      .par_typ (par_typ_q),
      .par_bit (exp_par)
   );

   // Frame sequencing; parity mode is frozen at the start bit.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      par_en_d    = par_en_q;
      par_typ_d   = par_typ_q;
      par_bit_d   = par_bit_q;
      stp_bad_d   = stp_bad_q;
      load_result = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bit_valid && !sampled_bit) begin
               state_d   = StData;
               bit_cnt_d = '0;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               par_bit_d = 1'b0;
               stp_bad_d = 1'b0;
            end
         end
         StData: begin
            if (bit_valid) begin
               // LSB arrives first, so shift in from the top.
               shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == BitLast) begin
                  state_d    = par_en_q ? StParity : StStop;
                  stop_cnt_d = 1'b0;
               end
            end
         end
         StParity: begin
            if (bit_valid) begin
               par_bit_d  = sampled_bit;
               state_d    = StStop;
               stop_cnt_d = 1'b0;
            end
         end
         StStop: begin
            if (bit_valid) begin
               stp_bad_d = stp_bad_q | ~sampled_bit;
               if (stop_cnt_q == StopLast) begin
                  state_d     = StDone;
                  load_result = 1'b1;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Saturating error counters; clear beats a coincident increment.
   always_comb begin
      par_cnt_d = par_cnt_q;
      stp_cnt_d = stp_cnt_q;
      if (cnt_clr) begin
         par_cnt_d = '0;
         stp_cnt_d = '0;
      end else if (state_q == StDone) begin
         if (par_err_q && par_cnt_q != CntMax) par_cnt_d = par_cnt_q + 1'b1;
         if (stp_err_q && stp_cnt_q != CntMax) stp_cnt_d = stp_cnt_q + 1'b1;
      end
   end

   // State registers; results load on the final stop strobe so they are valid in DONE.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         par_bit_q  <= 1'b0;
         stp_bad_q  <= 1'b0;
         pdata_q    <= '0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         par_cnt_q  <= '0;
         stp_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         par_bit_q  <= par_bit_d;
         stp_bad_q  <= stp_bad_d;
         par_cnt_q  <= par_cnt_d;
         stp_cnt_q  <= stp_cnt_d;
         if (load_result) begin
            pdata_q   <= shift_q;
            par_err_q <= par_en_q & (par_bit_q ^ exp_par);
            stp_err_q <= stp_bad_q | ~sampled_bit;
         end
      end
   end

   // Output decode.
   always_comb begin
      P_DATA      = pdata_q;
      par_err     = par_err_q;
      stp_err     = stp_err_q;
      frame_done  = (state_q == StDone);
      data_valid  = frame_done & ~(par_err_q | stp_err_q);
      busy        = (state_q != StIdle);
      par_err_cnt = par_cnt_q;
      stp_err_cnt = stp_cnt_q;
   end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench: instance 0 uses default parameters, instance 1 uses
// 7 data bits, 2 stop bits and 2-bit counters.
module tb_uart_rx_frame_check;

   typedef struct {
      int         d;
      logic [8:0] data;
      logic       pe;
      logic       se;
   } exp_t;

   logic       CLK;
   logic       RST;
   logic       bv   [2];
   logic       sb   [2];
   logic       pen  [2];
   logic [1:0] ptyp [2];
   logic       clr  [2];

   logic [7:0] pdata_a;
   logic [6:0] pdata_b;
   logic [7:0] pcnt_a, scnt_a;
   logic [1:0] pcnt_b, scnt_b;
   logic       fd [2], dv [2], pe [2], se [2], bz [2];
   logic [8:0] pd   [2];
   logic [7:0] pcnt [2];
   logic [7:0] scnt [2];

   exp_t sb_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   assign pd[0]   = {1'b0, pdata_a};
   assign pd[1]   = {2'b0, pdata_b};
   assign pcnt[0] = pcnt_a;
   assign pcnt[1] = {6'b0, pcnt_b};
   assign scnt[0] = scnt_a;
   assign scnt[1] = {6'b0, scnt_b};

   uart_rx_frame_check dut_a (
      .CLK         (CLK),
      .RST         (RST),
      .bit_valid   (bv[0]),
      .sampled_bit (sb[0]),
      .PAR_EN      (pen[0]),
      .PAR_TYP     (ptyp[0]),
      .cnt_clr     (clr[0]),
      .P_DATA      (pdata_a),
      .frame_done  (fd[0]),
      .data_valid  (dv[0]),
      .par_err     (pe[0]),
      .stp_err     (se[0]),
      .busy        (bz[0]),
      .par_err_cnt (pcnt_a),
      .stp_err_cnt (scnt_a)
   );

   uart_rx_frame_check #(
      .DATA_WIDTH (7),
      .STOP_BITS  (2),
      .CNT_WIDTH  (2)
   ) dut_b (
      .CLK         (CLK),
      .RST         (RST),
      .bit_valid   (bv[1]),
      .sampled_bit (sb[1]),
      .PAR_EN      (pen[1]),
      .PAR_TYP     (ptyp[1]),
      .cnt_clr     (clr[1]),
      .P_DATA      (pdata_b),
      .frame_done  (fd[1]),
      .data_valid  (dv[1]),
      .par_err     (pe[1]),
      .stp_err     (se[1]),
      .busy        (bz[1]),
      .par_err_cnt (pcnt_b),
      .stp_err_cnt (scnt_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference parity from a ones count.
   function automatic logic model_par(input logic [8:0] data, input int nbits,
                                      input logic [1:0] typ);
      int ones = 0;
      for (int i = 0; i < nbits; i++) ones += int'(data[i]);
      case (typ)
         2'b00:   return logic'(ones % 2);
         2'b01:   return logic'(1 - (ones % 2));
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Scoreboard: every frame_done pops one expectation.
   always @(negedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         if (fd[d] === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_done dut%0d: got frame_done=1, want none", d);
            end else begin
               e = sb_q.pop_front();
               if (e.d !== d) begin
                  errors++;
                  $display("FAIL frame_owner: got dut%0d, want dut%0d", d, e.d);
               end
               checks++;
               if (pd[d] !== e.data) begin
                  errors++;
                  $display("FAIL p_data dut%0d: got %h, want %h", d, pd[d], e.data);
               end
               checks++;
               if (pe[d] !== e.pe) begin
                  errors++;
                  $display("FAIL par_err dut%0d: got %b, want %b", d, pe[d], e.pe);
               end
               checks++;
               if (se[d] !== e.se) begin
                  errors++;
                  $display("FAIL stp_err dut%0d: got %b, want %b", d, se[d], e.se);
               end
               checks++;
               if (dv[d] !== !(e.pe | e.se)) begin
                  errors++;
                  $display("FAIL data_valid dut%0d: got %b, want %b", d, dv[d], !(e.pe | e.se));
               end
            end
         end
      end
   end

   task automatic strobe(input int d, input logic b);
      @(posedge CLK);
      #1;
      bv[d] = 1'b1;
      sb[d] = b;
      @(posedge CLK);
      #1;
      bv[d] = 1'b0;
      sb[d] = 1'b1;
   endtask

   // Sends one frame; returns #1 into the DONE cycle.
   task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                             input logic par_en, input logic [1:0] typ, input logic par_bit,
                             input logic [1:0] stops, input int nstop,
                             input int chg_at, input logic [1:0] chg_typ);
      exp_t x;
      x.d    = d;
      x.data = '0;
      for (int i = 0; i < nbits; i++) x.data[i] = data[i];
      x.pe   = par_en & (par_bit != model_par(data, nbits, typ));
      x.se   = 1'b0;
      for (int s = 0; s < nstop; s++) if (!stops[s]) x.se = 1'b1;
      sb_q.push_back(x);
      pen[d]  = par_en;
      ptyp[d] = typ;
      strobe(d, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) begin
            ptyp[d] = chg_typ;
            pen[d]  = ~par_en;
         end
         strobe(d, data[i]);
      end
      if (par_en) strobe(d, par_bit);
      for (int s = 0; s < nstop; s++) strobe(d, stops[s]);
      checks++;
      if (fd[d] !== 1'b1) begin
         errors++;
         $display("FAIL done_latency dut%0d: got frame_done=%b, want 1", d, fd[d]);
      end
   endtask

   task automatic check_cnt(input int d, input logic [7:0] want_p, input logic [7:0] want_s,
                            input string tag);
      checks++;
      if (pcnt[d] !== want_p) begin
         errors++;
         $display("FAIL %s par_err_cnt dut%0d: got %0d, want %0d", tag, d, pcnt[d], want_p);
      end
      checks++;
      if (scnt[d] !== want_s) begin
         errors++;
         $display("FAIL %s stp_err_cnt dut%0d: got %0d, want %0d", tag, d, scnt[d], want_s);
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      for (int d = 0; d < 2; d++) begin
         bv[d] = 1'b0; sb[d] = 1'b1; pen[d] = 1'b0; ptyp[d] = 2'b00; clr[d] = 1'b0;
      end
      repeat (2) @(posedge CLK);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({pd[d], fd[d], dv[d], pe[d], se[d], bz[d]} !== '0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got pd=%h fd=%b dv=%b pe=%b se=%b bz=%b, want 0",
                     d, pd[d], fd[d], dv[d], pe[d], se[d], bz[d]);
         end
         check_cnt(d, 8'd0, 8'd0, "reset");
      end
      RST = 1'b1;
      // A stop-level sample in IDLE must not start a frame.
      strobe(0, 1'b1);
      checks++;
      if (bz[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore_one: got busy=%b, want 0", bz[0]);
      end
   endtask

   task automatic test_even();
      send_frame(0, 9'h0A5, 8, 1'b1, 2'b00, 1'b0, 2'b01, 1, -1, 2'b00);
      @(posedge CLK);
      #1;
      check_cnt(0, 8'd0, 8'd0, "even");
   endtask

   task automatic test_odd();
      // 0x01 already has odd weight, so a 1 parity bit is the error.
      send_frame(0, 9'h001, 8, 1'b1, 2'b01, 1'b1, 2'b01, 1, -1, 2'b00);
      check_cnt(0, 8'd0, 8'd0, "odd_before");
      @(posedge CLK);
      #1;
      check_cnt(0, 8'd1, 8'd0, "odd_after");
   endtask

   task automatic test_back_to_back();
      send_frame(0, 9'h000, 8, 1'b1, 2'b00, 1'b0, 2'b01, 1, -1, 2'b00);
      // Start-bit level presented during DONE must be ignored.
      bv[0] = 1'b1;
      sb[0] = 1'b0;
      @(posedge CLK);
      #1;
      bv[0] = 1'b0;
      sb[0] = 1'b1;
      checks++;
      if (bz[0] !== 1'b0) begin
         errors++;
         $display("FAIL done_ignore: got busy=%b, want 0", bz[0]);
      end
      send_frame(0, 9'h0FF, 8, 1'b1, 2'b11, 1'b1, 2'b01, 1, -1, 2'b00);
      @(posedge CLK);
      #1;
      check_cnt(0, 8'd2, 8'd0, "b2b");
   endtask

   task automatic test_stop_err();
      send_frame(1, 9'h03C, 7, 1'b0, 2'b00, 1'b0, 2'b01, 2, -1, 2'b00);
      @(posedge CLK);
      #1;
      check_cnt(1, 8'd0, 8'd1, "stop");
   endtask

   task automatic test_mid_change();
      send_frame(1, 9'h003, 7, 1'b1, 2'b11, 1'b0, 2'b11, 2, 3, 2'b01);
      send_frame(1, 9'h003, 7, 1'b1, 2'b01, 1'b1, 2'b11, 2, -1, 2'b00);
      @(posedge CLK);
      #1;
      check_cnt(1, 8'd0, 8'd1, "mid_change");
   endtask

   task automatic test_saturate();
      for (int k = 1; k <= 5; k++) begin
         send_frame(1, 9'h001, 7, 1'b1, 2'b00, 1'b0, 2'b11, 2, -1, 2'b00);
         if (k == 5) clr[1] = 1'b1;
         @(posedge CLK);
         #1;
         clr[1] = 1'b0;
         if (k < 5) check_cnt(1, (k < 3) ? 8'(k) : 8'd3, 8'd1, "saturate");
         else check_cnt(1, 8'd0, 8'd0, "clear_wins");
      end
      checks++;
      if (pe[1] !== 1'b1 || pd[1] !== 9'h001) begin
         errors++;
         $display("FAIL clr_keeps_flags: got pe=%b pd=%h, want pe=1 pd=001", pe[1], pd[1]);
      end
   endtask

   task automatic test_reset_abort();
      pen[0]  = 1'b1;
      ptyp[0] = 2'b10;
      strobe(0, 1'b0);
      for (int i = 0; i < 4; i++) strobe(0, 1'b1);
      RST = 1'b0;
      #1;
      checks++;
      if (bz[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_busy: got busy=%b, want 0", bz[0]);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      repeat (12) @(posedge CLK);
      #1;
      check_cnt(0, 8'd0, 8'd0, "abort");
      send_frame(0, 9'h05A, 8, 1'b1, 2'b10, 1'b1, 2'b01, 1, -1, 2'b00);
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd();
      test_back_to_back();
      test_stop_err();
      test_mid_change();
      test_saturate();
      test_reset_abort();
      repeat (5) @(posedge CLK);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL missing_frame_done: got %0d pending, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
